// File: rtl/game_state_ctrl.sv
// game_state_ctrl: IDLE/RUN/OVER/CLEAR sequencer driving gameState, ScoreClock and speed_level
module game_state_ctrl #(
    parameter int HALF_PERIOD = 1_250_000,
    parameter int LOCKOUT     = 25_000_000,
    parameter int SPEED_STEP  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump_btn,
    input  logic       collision,
    output logic [1:0] gameState,
    output logic       ScoreClock,
    output logic [2:0] speed_level
);
    localparam int DW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
    localparam int LW = LOCKOUT > 0 ? $clog2(LOCKOUT + 1) : 1;
    localparam int TW = SPEED_STEP > 1 ? $clog2(SPEED_STEP) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(HALF_PERIOD - 1);
    localparam logic [LW-1:0] LK_MAX  = LW'(LOCKOUT);
    localparam logic [TW-1:0] TK_MAX  = TW'(SPEED_STEP - 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER, CLEAR} state_t;

    state_t          state, state_d;
    logic            s1, s2, s3;
    logic [DW-1:0]   div_cnt;
    logic [LW-1:0]   lk_cnt;
    logic [TW-1:0]   tk_cnt;
    logic            ec;
    logic [1:0]      gs_d;
    logic            jump_rise, div_wrap, sc_rise, lk_done, tk_wrap, enter_clear, run_tick;

    assign jump_rise   = s2 & ~s3;
    assign div_wrap    = div_cnt == DIV_MAX;
    assign sc_rise     = div_wrap & ~ScoreClock;
    assign lk_done     = lk_cnt == LK_MAX;
    assign tk_wrap     = tk_cnt == TK_MAX;
    assign enter_clear = (state == OVER) && (state_d == CLEAR);
    assign run_tick    = (state == RUN) && sc_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = jump_rise ? RUN : IDLE;
            RUN:   state_d = collision ? OVER : RUN;
            OVER:  state_d = (jump_rise && lk_done) ? CLEAR : OVER;
            CLEAR: state_d = (sc_rise && ec) ? RUN : CLEAR;
        endcase
    end

    always_comb begin
        gs_d = (state_d == RUN) ? 2'b10 : (state_d == OVER) ? 2'b01 : 2'b00;
    end

    // ec flags the first ScoreClock rise seen in CLEAR; the second one releases to RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {s1, s2, s3} <= 3'b000;
            div_cnt      <= '0;
            ScoreClock   <= 1'b0;
            lk_cnt       <= '0;
            ec           <= 1'b0;
            tk_cnt       <= '0;
            speed_level  <= 3'd0;
            gameState    <= 2'b00;
        end else begin
            s1          <= jump_btn;
            s2          <= s1;
            s3          <= s2;
            div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
            ScoreClock  <= ScoreClock ^ div_wrap;
            lk_cnt      <= (state != OVER) ? '0 : lk_done ? lk_cnt : lk_cnt + 1'b1;
            ec          <= (state == CLEAR) && (ec | sc_rise);
            tk_cnt      <= enter_clear ? '0 : run_tick ? (tk_wrap ? '0 : tk_cnt + 1'b1) : tk_cnt;
            speed_level <= enter_clear ? 3'd0 :
                           (run_tick && tk_wrap && speed_level != 3'd7) ? speed_level + 3'd1 : speed_level;
            gameState   <= gs_d;
        end
    end
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scenario bench for game_state_ctrl (HALF_PERIOD=4, LOCKOUT=20, SPEED_STEP=3)
module tb_game_state_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       jump_btn = 1'b0;
    logic       collision = 1'b0;
    logic [1:0] gameState;
    logic       ScoreClock;
    logic [2:0] speed_level;
    int         n_chk = 0;
    int         n_fail = 0;

    game_state_ctrl #(.HALF_PERIOD(4), .LOCKOUT(20), .SPEED_STEP(3)) dut (
        .clk(clk), .rst(rst), .jump_btn(jump_btn), .collision(collision),
        .gameState(gameState), .ScoreClock(ScoreClock), .speed_level(speed_level)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL reset_gs: got %b want 00", gameState); end
        n_chk++; if (speed_level !== 3'd0) begin n_fail++; $display("FAIL reset_speed: got %0d want 0", speed_level); end
        n_chk++; if (ScoreClock !== 1'b0) begin n_fail++; $display("FAIL reset_sc: got %b want 0", ScoreClock); end
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_chk++; if (ScoreClock !== (c == 4)) begin n_fail++; $display("FAIL first_rise c=%0d: got %b want %b", c, ScoreClock, c == 4); end
        end
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL idle_after_release: got %b want 00", gameState); end
    endtask

    task automatic test_start;
        jump_btn = 1'b1;
        @(negedge clk);
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL start_e1: got %b want 00", gameState); end
        @(negedge clk);
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL start_e2: got %b want 00", gameState); end
        jump_btn = 1'b0;
        @(negedge clk);
        n_chk++; if (gameState !== 2'b10) begin n_fail++; $display("FAIL start_e3: got %b want 10", gameState); end
    endtask

    task automatic test_collision_priority;
        repeat (3) @(negedge clk);
        jump_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (gameState !== 2'b10) begin n_fail++; $display("FAIL prio_pre: got %b want 10", gameState); end
        collision = 1'b1;
        @(negedge clk);
        n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL prio_over: got %b want 01", gameState); end
        collision = 1'b0;
        jump_btn = 1'b0;
    endtask

    task automatic test_lockout;
        for (int c = 1; c <= 27; c++) begin
            jump_btn = (c >= 10 && c < 13) || (c >= 25 && c < 28);
            @(negedge clk);
            if (c < 27) begin
                n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL lockout c=%0d: got %b want 01", c, gameState); end
            end else begin
                n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL lockout_clear: got %b want 00", gameState); end
            end
        end
        jump_btn = 1'b0;
    endtask

    task automatic test_clear_dwell;
        logic prev, rose, done;
        int   rises, dwell;
        prev = ScoreClock; done = 1'b0; rises = 0; dwell = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            rose = ScoreClock && !prev;
            prev = ScoreClock;
            if (gameState === 2'b10) begin
                done = 1'b1;
                dwell = c;
                n_chk++; if (rose !== 1'b1) begin n_fail++; $display("FAIL run_on_rise: got %b want 1", rose); end
            end else if (rose) rises++;
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL clear_timeout: got %b want 1", done); end
        n_chk++; if (rises != 1) begin n_fail++; $display("FAIL rises_in_clear: got %0d want 1", rises); end
        n_chk++; if (dwell < 9 || dwell > 16) begin n_fail++; $display("FAIL clear_dwell: got %0d want 9..16", dwell); end
    endtask

    task automatic test_speed_saturation;
        logic prev, done;
        int   r, e;
        prev = ScoreClock; r = 0; done = 1'b0;
        for (int c = 0; c < 300 && r < 30; c++) begin
            @(negedge clk);
            if (ScoreClock && !prev) begin
                r++;
                e = (r / 3 > 7) ? 7 : r / 3;
                n_chk++; if (speed_level !== 3'(e)) begin n_fail++; $display("FAIL speed r=%0d: got %0d want %0d", r, speed_level, e); end
            end
            prev = ScoreClock;
        end
        n_chk++; if (r != 30) begin n_fail++; $display("FAIL speed_rises: got %0d want 30", r); end
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL speed_over: got %b want 01", gameState); end
        repeat (30) @(negedge clk);
        n_chk++; if (speed_level !== 3'd7) begin n_fail++; $display("FAIL speed_hold: got %0d want 7", speed_level); end
        jump_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL restart_pre: got %b want 01", gameState); end
        @(negedge clk);
        jump_btn = 1'b0;
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL restart_clear: got %b want 00", gameState); end
        n_chk++; if (speed_level !== 3'd0) begin n_fail++; $display("FAIL speed_clear: got %0d want 0", speed_level); end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            done = gameState === 2'b10;
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_run: got %b want 1", done); end
    endtask

    task automatic test_held_button;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        jump_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL held_pre: got %b want 00", gameState); end
        @(negedge clk);
        n_chk++; if (gameState !== 2'b10) begin n_fail++; $display("FAIL held_run: got %b want 10", gameState); end
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL held_over: got %b want 01", gameState); end
        repeat (30) @(negedge clk);
        n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL held_no_edge: got %b want 01", gameState); end
        jump_btn = 1'b0;
        repeat (3) @(negedge clk);
        jump_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (gameState !== 2'b01) begin n_fail++; $display("FAIL repress_pre: got %b want 01", gameState); end
        @(negedge clk);
        jump_btn = 1'b0;
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL repress_clear: got %b want 00", gameState); end
    endtask

    task automatic test_async_reset_clear;
        logic prev, found;
        prev = ScoreClock; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = ScoreClock && !prev;
            prev = ScoreClock;
        end
        n_chk++; if (found !== 1'b1) begin n_fail++; $display("FAIL clear_first_rise: got %b want 1", found); end
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL mid_clear_gs: got %b want 00", gameState); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (ScoreClock !== 1'b0) begin n_fail++; $display("FAIL async_sc: got %b want 0", ScoreClock); end
        n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL async_gs: got %b want 00", gameState); end
        n_chk++; if (speed_level !== 3'd0) begin n_fail++; $display("FAIL async_speed: got %0d want 0", speed_level); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_chk++; if (gameState !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle c=%0d: got %b want 00", c, gameState); end
        end
    endtask

    initial begin
        test_reset;
        test_start;
        test_collision_priority;
        test_lockout;
        test_clear_dwell;
        test_speed_saturation;
        test_held_button;
        test_async_reset_clear;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer that sits directly upstream of the score board. It produces the `gameState` code and the `ScoreClock` that the score board consumes. It turns the player's jump button and the collision flag into IDLE / RUN / OVER phases, and guarantees the score board sees a clear (`2'b00`) on a `ScoreClock` edge before every restart. It also emits a saturating speed level for the obstacle generator.

## Interface
Parameters:
- `HALF_PERIOD`, default 1_250_000: clk cycles per half period of `ScoreClock` (20 Hz at 50 MHz).
- `LOCKOUT`, default 25_000_000: clk cycles after entering OVER during which the jump button is ignored.
- `SPEED_STEP`, default 100: `ScoreClock` rising edges in RUN per speed-level increment.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `jump_btn`  in  1  raw push-button, asynchronous to `clk`, active-high.
- `collision`  in  1  level, synchronous to `clk`, high while the dino overlaps an obstacle.
- `gameState`  out  2  00 = idle/clear, 10 = running, 01 = game over; registered.
- `ScoreClock`  out  1  50 % duty square wave, registered.
- `speed_level`  out  3  0..7, registered.

## Operation
- **Button path:** 2-FF synchronizer (`s1`, `s2`) plus one history FF (`s3`). `jump_rise = s2 & ~s3`, a single-cycle pulse per press.
- **Divider:** free-running counter 0..HALF_PERIOD-1.
  - On wrap, `ScoreClock` toggles.
  - `sc_rise` is an internal one-cycle pulse in the cycle `ScoreClock` is driven 0→1.
  - The divider runs in every state and is never restarted except by reset.
- **FSM** (internal states; `gameState` encoding in brackets):
  - IDLE [00]: `jump_rise` → RUN.
  - RUN [10]: `collision` → OVER. Collision has priority over `jump_rise` in the same cycle; `jump_rise` is otherwise ignored.
  - OVER [01]: on entry, the lockout counter loads 0 and counts up to LOCKOUT, then holds.
    - `jump_rise` while counter < LOCKOUT is discarded, not queued.
    - `jump_rise` with counter == LOCKOUT → CLEAR.
  - CLEAR [00]: on entry, the edge counter is cleared. It counts `sc_rise` pulses; after the 2nd → RUN.
    - This guarantees at least one full `ScoreClock` rising edge is sampled with `gameState == 00`, which zeroes the score digits.
    - `jump_rise` and `collision` are ignored.
- `collision` is ignored in IDLE, OVER and CLEAR.
- **Speed:** tick counter 0..SPEED_STEP-1 advances on `sc_rise` only while in RUN.
  - On wrap, `speed_level` increments, saturating at 7 (the counter keeps wrapping at saturation).
  - Both the tick counter and `speed_level` clear on entry to CLEAR.
  - Both hold in OVER and IDLE.
- **Reset (`rst` low, any time):**
  - State → IDLE; `gameState` = 00.
  - `ScoreClock` = 0; `speed_level` = 0.
  - All counters and synchronizer FFs = 0.
  - Takes effect immediately, mid-game included. Release is synchronous to the next `clk` edge.

## Timing
- `jump_btn` rising before `clk` edge k: `s1` set at k, `s2` at k+1, `jump_rise` high for the cycle after k+1. The state/`gameState` update is at edge k+2, so latency is 3 edges.
- `collision` high before edge k in RUN: `gameState` = 01 after edge k (1 cycle).
- `ScoreClock` first rises HALF_PERIOD cycles after reset release; period is 2·HALF_PERIOD.
- CLEAR dwell is between 2·HALF_PERIOD+1 and 4·HALF_PERIOD cycles, depending on divider phase.
- `gameState` goes 00→10 on the same edge the 2nd `sc_rise` is consumed.
- A button held high gives exactly one `jump_rise`. Releasing and re-pressing gives another.
- `speed_level` updates on the edge consuming the SPEED_STEP-th `sc_rise` in RUN.

## Test plan
Bench parameters: HALF_PERIOD=4, LOCKOUT=20, SPEED_STEP=3.
1. **Reset and start:** `rst` low then released.
   - After release: `gameState`=00, `speed_level`=0, `ScoreClock`=0; first `ScoreClock` rise 4 cycles after release.
   - Pulse `jump_btn`: `gameState`=10 exactly 3 edges later.
2. **Collision:** `collision` high in RUN → `gameState`=01 next edge. Set `collision` and `jump_btn` together in RUN → 01, not restart.
3. **Lockout:**
   - Press `jump_btn` 10 cycles into OVER → stays 01, also after the counter expires.
   - Press again at 25 cycles → 00 (CLEAR), then 10 after the 2nd `ScoreClock` rise. Confirm at least one `ScoreClock` rise occurs while 00.
4. **Speed saturation:** run 30 `ScoreClock` rises in RUN.
   - `speed_level` steps 1..7 every 3 rises, then stays 7.
   - Enter OVER and hold → `speed_level` holds 7. Restart → `speed_level` 0 on CLEAR entry.
5. **Held button:** hold `jump_btn` high across IDLE→RUN, then collide, then wait past lockout → remains 01 (no second edge). Release and re-press → CLEAR.
6. **Async reset mid-CLEAR:** assert `rst` between the two `ScoreClock` rises.
   - Outputs go 00/0/0 without waiting for `clk`.
   - After release: IDLE, with no spontaneous transition to RUN.
